mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the five-stage DLX pipeline. It serialises one outstanding transaction at a time, gives priority to the data side with a bounded starvation guard for fetch, and produces the per-stage stall signals consumed by the pipeline control. It also drops fetch responses that a taken branch or jump has squashed.

## Interface
Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch waits (must be ≥1)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- if_req  in  1  fetch request, held until if_done or withdrawn
- if_addr  in  32  fetch word address
- if_flush  in  1  squash the current or pending fetch (taken branch/jump)
- if_rdata  out  32  fetched instruction, valid when if_done=1
- if_done  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_done
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  byte enables (sb/sh/sw)
- d_rdata  out  32  load data, valid when d_done=1
- d_done  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_done
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/32/32/4  registered transaction fields
- mem_ack  in  1  memory accepted/completed; may assert in the first mem_req cycle
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE arbitration, evaluated each cycle:
  - d_req & (~if_req_eff | starve_cnt < STARVE_LIMIT) -> D_BUSY.
  - else if_req_eff -> IF_BUSY.
  - if_req_eff = if_req & ~if_flush.
- On grant, latch the winner's fields into the mem_* registers and set mem_req=1. Fields stay stable until mem_ack.
- IF_BUSY/D_BUSY: on mem_ack, capture mem_rdata into a shared read register, drop mem_req, go to RESP.
- RESP, one cycle:
  - Pulse the owner's done signal, then go to IDLE.
  - Requests are not sampled in RESP. The requester updates or drops its req on the edge that sees done.
- Fetch squash:
  - if_flush sampled high in any cycle of IF_BUSY sets a sticky kill flag. The memory transaction still completes.
  - In RESP with the flag set, if_done stays 0. The flag clears on leaving RESP.
  - if_flush during D_BUSY or RESP(data) has no effect.
- starve_cnt, width clog2(STARVE_LIMIT+1), saturating:
  - Data grant with if_req_eff=1: +1.
  - Data grant with if_req_eff=0: cleared to 0.
  - Any IF grant: cleared to 0.
- if_rdata and d_rdata both drive the shared read register. It is captured on every mem_ack, including stores.
- Stall outputs are combinational from the request and done signals.

## Timing
- Reset values:
  - state=IDLE, mem_req=0, all mem_* fields 0.
  - if_done=d_done=0, read register 0, starve_cnt=0, kill flag 0.
- Reset asserted mid-transaction forces mem_req=0 asynchronously and abandons the transaction. The memory model must tolerate this.
- Latency with a zero-wait memory:
  - Grant at cycle t (IDLE).
  - mem_req high at t+1, with mem_ack at t+1.
  - done at t+2.
  - Next grant at t+3.
  - Memory wait states add k cycles between t+1 and done.
- Back-to-back throughput: one transaction per 3 cycles at zero wait.
- done is exactly one cycle wide. rdata holds its value until the next mem_ack.
- Simultaneous d_req and if_req with starve_cnt=STARVE_LIMIT: IF wins, and the counter clears.
- if_flush asserted in the same IDLE cycle as if_req: no IF grant. d_req may still win.

## Test plan
- Single load, zero-wait memory: d_req=1, d_we=0, d_addr=0x100, mem_rdata=0xDEADBEEF at ack -> mem_req high 1 cycle, d_done at t+2, d_rdata=0xDEADBEEF, if_done never asserts.
- Store with 3 wait states: d_we=1, d_be=4'b0001, d_wdata=0x000000AB -> mem_* fields stable for 4 cycles, d_stall=1 until d_done at t+5.
- Starvation, STARVE_LIMIT=4: if_req and d_req held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF; if_done carries the if_addr word.
- Squash: IF grant, if_flush pulsed in the second IF_BUSY cycle, mem_ack 2 cycles later -> RESP occurs, if_done=0, next IDLE accepts the new if_addr.
- Reset mid-transaction: rst_n low during D_BUSY -> mem_req=0 and state IDLE in the same cycle; after release, a fresh d_req is served normally with starve_cnt=0.
- Simultaneous first request: if_req and d_req rise together from reset -> data granted first, IF granted on the next IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and data access,
// one transaction at a time, data-first with a bounded starvation guard for fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

  state_t          state, state_d;
  logic            mem_req_d, mem_we_d;
  logic [31:0]     mem_addr_d, mem_wdata_d;
  logic [3:0]      mem_be_d;
  logic [31:0]     rdata, rdata_d;
  logic            if_done_d, d_done_d;
  logic            kill, kill_d;
  logic [CW-1:0]   starve_cnt, starve_cnt_d;
  logic            if_req_eff, d_win;

  assign if_req_eff = if_req & ~if_flush;
  assign d_win      = d_req & (~if_req_eff | (starve_cnt < CW'(STARVE_LIMIT)));

  // Next-state and next-register values
  always_comb begin
    state_d      = state;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_be_d     = mem_be;
    rdata_d      = rdata;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    kill_d       = kill;
    starve_cnt_d = starve_cnt;
    unique case (state)
      IDLE: begin
        if (d_win) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          // Count data grants that bypass a waiting fetch; saturate at the limit
          if (!if_req_eff)
            starve_cnt_d = '0;
          else if (starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt + CW'(1);
        end else if (if_req_eff) begin
          state_d      = IF_BUSY;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = 4'hF;
          starve_cnt_d = '0;
        end
      end
      IF_BUSY: begin
        if (if_flush) kill_d = 1'b1;
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RESP;
          if_done_d = ~(kill | if_flush);
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RESP;
          d_done_d  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      rdata      <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      kill       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_be     <= mem_be_d;
      rdata      <= rdata_d;
      if_done    <= if_done_d;
      d_done     <= d_done_d;
      kill       <= kill_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  assign if_rdata = rdata;
  assign d_rdata  = rdata;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

endmodule
